// File: rtl/cla_pkg.sv
// Shared types for the nibble-serial carry-lookahead sequencer.
package cla_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cla_seq_state_t;

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is expanded from generate/propagate terms, so none waits on its neighbour.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c[3:0];
  assign co = c[4];

endmodule

// File: rtl/cla_nibble_seq_ctrl.sv
// Adds or subtracts WIDTH-bit operands one nibble per clock through a single
// 4-bit CLA slice, with valid/ready handshakes on both the request and result sides.
module cla_nibble_seq_ctrl
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int NNIB = WIDTH / NIB_W;
  localparam int IDXW = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NNIB - 1);

  cla_seq_state_t   state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [NIB_W-1:0] nib_a;
  logic [NIB_W-1:0] nib_b;
  logic [NIB_W-1:0] nib_s;
  logic             nib_co;

  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int n = 0; n < NNIB; n++) begin
      if (idx_q == IDXW'(n)) begin
        nib_a = a_q[n*NIB_W +: NIB_W];
        nib_b = b_q[n*NIB_W +: NIB_W];
      end
    end
  end

  cla4_slice u_slice (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry_q),
    .s  (nib_s),
    .co (nib_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        // Subtraction is A + ~B + !borrow, so B is stored pre-inverted.
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_cin ^ in_sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int n = 0; n < NNIB; n++) begin
          if (idx_q == IDXW'(n)) sum_d[n*NIB_W +: NIB_W] = nib_s;
        end
        carry_d = nib_co;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          cout_d  = nib_co;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_s[NIB_W-1] != a_q[WIDTH-1]);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_cla_nibble_seq_ctrl.sv
// Bench for cla_nibble_seq_ctrl at WIDTH=16: directed cases, randomized operations
// against an integer reference model, backpressure and mid-operation reset.
module tb_cla_nibble_seq_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  cla_nibble_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic cin, input logic sub,
                                    output logic [W-1:0] s, output logic co, output logic ov);
    longint ua, ub, sa, sb, c, u, sr;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    c  = cin;
    if (!sub) begin
      u  = ua + ub + c;
      co = (u > 65535);
      sr = sa + sb + c;
    end else begin
      u  = ua - ub - c;
      co = (ua >= ub + c);
      sr = sa - sb - c;
    end
    s  = u[W-1:0];
    ov = (sr > 32767) || (sr < -32768);
  endfunction

  // Drives one request, waits for the result, holds out_ready low for 'hold' cycles,
  // then completes the result handshake. Returns the observed result and latency.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input int hold, output logic [W-1:0] s,
                       output logic co, output logic ov, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom);
    in_cin = 1'($urandom); in_sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    s = out_sum; co = out_cout; ov = out_ovf;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) begin
      @(posedge clk); #1;
    end
    vectors++;
    if ({in_ready, out_valid, busy, out_cout, out_ovf} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_ctrl got=%b exp=10000", {in_ready, out_valid, busy, out_cout, out_ovf});
    end
    vectors++;
    if (out_sum !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_sum got=%h exp=0000", out_sum);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_release got=%b exp=100", {in_ready, out_valid, busy});
    end
  endtask

  logic [W-1:0] d_a   [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
  logic [W-1:0] d_b   [5] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
  logic         d_sub [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [W-1:0] d_sum [5] = '{16'h5555, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
  logic         d_co  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic         d_ov  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic test_directed();
    logic [W-1:0] s;
    logic co, ov;
    int lat;
    for (int i = 0; i < 5; i++) begin
      do_op(d_a[i], d_b[i], 1'b0, d_sub[i], 0, s, co, ov, lat);
      vectors++;
      if (lat != 4) begin
        miscompares++;
        $display("FAIL directed%0d_latency got=%0d exp=4", i + 1, lat);
      end
      vectors++;
      if ({s, co, ov} !== {d_sum[i], d_co[i], d_ov[i]}) begin
        miscompares++;
        $display("FAIL directed%0d_result got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                 i + 1, s, co, ov, d_sum[i], d_co[i], d_ov[i]);
      end
      vectors++;
      if ({out_valid, in_ready, busy} !== 3'b010) begin
        miscompares++;
        $display("FAIL directed%0d_handshake got=%b exp=010", i + 1, {out_valid, in_ready, busy});
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, s, es;
    logic cin, sub, co, ov, eco, eov;
    int lat;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom); b = W'($urandom);
      if (i % 8 == 0) b = ~a;
      cin = 1'($urandom); sub = 1'($urandom);
      ref_model(a, b, cin, sub, es, eco, eov);
      do_op(a, b, cin, sub, int'($urandom_range(0, 3)), s, co, ov, lat);
      vectors++;
      if (lat != 4 || {s, co, ov} !== {es, eco, eov}) begin
        miscompares++;
        $display("FAIL random%0d a=%h b=%h cin=%b sub=%b got sum=%h cout=%b ovf=%b lat=%0d exp sum=%h cout=%b ovf=%b lat=4",
                 i, a, b, cin, sub, s, co, ov, lat, es, eco, eov);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a1, b1, a2, b2, es1, es2;
    logic eco1, eov1, eco2, eov2;
    int lat;
    a1 = W'($urandom); b1 = W'($urandom);
    a2 = W'($urandom); b2 = W'($urandom);
    ref_model(a1, b1, 1'b1, 1'b0, es1, eco1, eov1);
    ref_model(a2, b2, 1'b0, 1'b1, es2, eco2, eov2);
    in_a = a1; in_b = b1; in_cin = 1'b1; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int k = 0; k < 6; k++) begin
      if (k == 2) begin
        in_a = a2; in_b = b2; in_cin = 1'b0; in_sub = 1'b1; in_valid = 1'b1;
      end
      vectors++;
      if ({out_valid, in_ready, busy, out_sum, out_cout, out_ovf} !== {3'b101, es1, eco1, eov1}) begin
        miscompares++;
        $display("FAIL bp_hold%0d got v/r/b=%b sum=%h cout=%b ovf=%b exp v/r/b=101 sum=%h cout=%b ovf=%b",
                 k, {out_valid, in_ready, busy}, out_sum, out_cout, out_ovf, es1, eco1, eov1);
      end
      if (k < 5) begin
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if ({out_valid, in_ready, busy, out_sum} !== {3'b010, es1}) begin
      miscompares++;
      $display("FAIL bp_after_handshake got v/r/b=%b sum=%h exp v/r/b=010 sum=%h",
               {out_valid, in_ready, busy}, out_sum, es1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if ({in_ready, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL bp_accept_next got r/b=%b exp r/b=01", {in_ready, busy});
    end
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (lat != 4 || {out_sum, out_cout, out_ovf} !== {es2, eco2, eov2}) begin
      miscompares++;
      $display("FAIL bp_second_op got sum=%h cout=%b ovf=%b lat=%0d exp sum=%h cout=%b ovf=%b lat=4",
               out_sum, out_cout, out_ovf, lat, es2, eco2, eov2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midrun();
    logic [W-1:0] s;
    logic co, ov;
    int lat;
    in_a = 16'h1234; in_b = 16'h4321; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({in_ready, out_valid, busy, out_sum, out_cout, out_ovf} !== {3'b100, 16'h0000, 2'b00}) begin
      miscompares++;
      $display("FAIL midrun_reset got r/v/b=%b sum=%h cout=%b ovf=%b exp r/v/b=100 sum=0000 cout=0 ovf=0",
               {in_ready, out_valid, busy}, out_sum, out_cout, out_ovf);
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    vectors++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL midrun_reset_held got=%b exp=100", {in_ready, out_valid, busy});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1, s, co, ov, lat);
    vectors++;
    if (lat != 4 || {s, co, ov} !== {16'h5555, 2'b00}) begin
      miscompares++;
      $display("FAIL midrun_rerun got sum=%h cout=%b ovf=%b lat=%0d exp sum=5555 cout=0 ovf=0 lat=4",
               s, co, ov, lat);
    end
  endtask

  initial begin
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
